ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single RAM socket between two bus masters on the bridge: CPU (id 0) and VGA refresh/fetch (id 1).
- Per-requester req/ack handshake with round-robin grant, address-window and alignment checking, and a RAM response timeout.
- Sits inside the bridge between the CPU/VGA sockets and the RAM socket; one transaction in flight at a time.

Parameters:
- RAM_BASE, 32'h0020_0000, lowest legal RAM byte address (2M); anything below is rejected.
- TIMEOUT, 16, max cycles in ISSUE waiting for ram_ready before aborting with error.

Ports:
- clk  in  1  bridge clock.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  32  byte address, word aligned.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data, valid while cpu_ack.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_err  out  1  qualifies cpu_ack: transaction failed.
- vga_req, vga_we, vga_addr, vga_wdata, vga_rdata, vga_ack, vga_err: same as the cpu_* ports, for VGA.
- ram_req  out  1  RAM access strobe, held until ram_ready.
- ram_we  out  1  RAM write enable.
- ram_addr  out  32  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid with ram_ready.
- ram_ready  in  1  RAM completion, one cycle.
- busy  out  1  high in any state except IDLE.
- grant_id  out  1  id of the owner of the current or last transaction.

Behaviour:
- Reset (async): state = IDLE; all outputs 0; last_grant = 1, so the CPU wins the first tie; timeout counter = 0; latched request registers = 0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE, no req: stay in IDLE.
- IDLE, one or more req: pick the winner.
  - If only one requester is active, it wins.
  - If both are active, the id != last_grant wins.
  - Latch we/addr/wdata and the winner id; update last_grant and grant_id.
- IDLE, illegal address: if the latched addr < RAM_BASE or addr[1:0] != 0, go to RESP with err = 1. ram_req is never raised.
- IDLE, legal address: go to ISSUE.
- ISSUE:
  - ram_req = 1; ram_we/ram_addr/ram_wdata are driven from the latched registers and stay stable for the whole state.
  - ram_ready = 1: capture ram_rdata (reads only; writes return 0), err = 0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without ram_ready, go to RESP with err = 1 and rdata = 0.
  - ram_ready arriving on the same cycle as the timeout wins: completes with err = 0.
- RESP:
  - Exactly one cycle with the granted requester's ack = 1, err and rdata valid. The other requester's ack stays 0.
  - Clear ram_req and the counter; go to IDLE.
- ram_req is combinationally high only in ISSUE; it drops the cycle after ram_ready.
- Minimum latency: req seen at cycle N → ram_req at N+1 → with ram_ready at N+1, ack at N+2. Rejected address: ack+err at N+1.
- Requesters must drop req on the cycle after ack. A req still high in IDLE is a new transaction; back-to-back transactions are legal.
- Dropping req mid-transaction does not abort. The transaction completes and ack is still pulsed.
- ram_ready outside ISSUE is ignored.
- rdata outputs hold the last value between acks; an error forces rdata = 0.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. No ack is produced for the aborted transaction.

Decomposition:
- Shared package bridge_pkg:
  - memory map constants: BIOS_BASE 0, CTRL_BASE 32'h8000, SOUND_BASE 32'hC000, VGA_BASE 32'h0010_0000, RAM_BASE 32'h0020_0000;
  - requester ids: ID_CPU = 0, ID_VGA = 1;
  - ram_arbiter state encoding.
- One sub-module, rr_arb2: combinational two-input round-robin pick from the req pair and last_grant; outputs a valid bit and the winner id. All state stays in ram_arbiter.

Test Plan:
- CPU read at 32'h0020_0010; RAM returns 32'hDEAD_BEEF with ram_ready the cycle after ram_req → ram_addr = 32'h0020_0010, ram_we = 0, cpu_ack at req+2 with cpu_rdata = 32'hDEAD_BEEF, cpu_err = 0, vga_ack stays 0.
- cpu_req and vga_req both high in the same cycle after reset, each re-requesting immediately after its ack → grant order CPU, VGA, CPU, VGA; grant_id alternates; no ack overlap.
- VGA write of 32'h1234_5678 to 32'h0000_4000 (below RAM_BASE), and CPU access to 32'h0020_0002 (misaligned) → ack+err one cycle after req; ram_req never asserted.
- RAM never asserts ram_ready with TIMEOUT = 16 → ram_req high for exactly 16 cycles, then cpu_ack with cpu_err = 1 and cpu_rdata = 0. Repeat with ram_ready on exactly the 16th cycle → err = 0.
- rst pulsed while in ISSUE with ram_req high → ram_req, busy and all acks 0 immediately. After release, a pending vga_req and cpu_req resolve CPU first.
- CPU drops cpu_req while its request is in ISSUE → transaction still completes; cpu_ack pulses once; arbiter returns to IDLE with busy = 0.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared bridge definitions: memory map, requester ids and the RAM arbiter state encoding.
// Address legality for the RAM window lives here so every bridge block applies the same rule.
package bridge_pkg;

    localparam logic [31:0] BIOS_BASE  = 32'h0000_0000;
    localparam logic [31:0] CTRL_BASE  = 32'h0000_8000;
    localparam logic [31:0] SOUND_BASE = 32'h0000_C000;
    localparam logic [31:0] VGA_BASE   = 32'h0010_0000;
    localparam logic [31:0] RAM_BASE   = 32'h0020_0000;

    localparam logic ID_CPU = 1'b0;
    localparam logic ID_VGA = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_e;

    // Legal RAM access: at or above the window base and word aligned.
    function automatic logic ram_addr_legal(input logic [31:0] addr, input logic [31:0] base);
        return (addr >= base) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin pick: a lone requester wins, a tie goes to the id that did not win last.
// Purely combinational; the last_grant history is owned by the caller.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       grant
);

    always_comb begin
        valid = |req;
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the RAM socket between the CPU (id 0) and VGA (id 1): one transaction in flight,
// round-robin grant, address-window/alignment rejection and a ram_ready timeout.
//
// Handshake: a requester holds req (with we/addr/wdata stable) until it sees ack, which is a
// single-cycle pulse qualified by err and carrying rdata; the RAM side holds ram_req with stable
// ram_we/ram_addr/ram_wdata until ram_ready, a single-cycle completion.
module ram_arbiter
    import bridge_pkg::*;
#(
    parameter logic [31:0] RAM_BASE = bridge_pkg::RAM_BASE,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_err,

    input  logic        vga_req,
    input  logic        vga_we,
    input  logic [31:0] vga_addr,
    input  logic [31:0] vga_wdata,
    output logic [31:0] vga_rdata,
    output logic        vga_ack,
    output logic        vga_err,

    output logic        ram_req,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ready,

    output logic        busy,
    output logic        grant_id,
    output arb_state_e  dbg_state
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_e    state;
    logic          last_grant;
    logic          cur_id;
    logic          lat_we;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic [CW-1:0] cnt;

    logic          arb_valid;
    logic          arb_id;
    logic          sel_we;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;

    logic          fire;
    logic          fire_id;
    logic          fire_err;
    logic [31:0]   fire_data;

    rr_arb2 u_rr_arb2 (
        .req        ({vga_req, cpu_req}),
        .last_grant (last_grant),
        .valid      (arb_valid),
        .grant      (arb_id)
    );

    always_comb begin
        sel_we    = (arb_id == ID_VGA) ? vga_we    : cpu_we;
        sel_addr  = (arb_id == ID_VGA) ? vga_addr  : cpu_addr;
        sel_wdata = (arb_id == ID_VGA) ? vga_wdata : cpu_wdata;
    end

    // Completion event for this cycle; a rejected address completes straight from IDLE.
    always_comb begin
        fire      = 1'b0;
        fire_id   = cur_id;
        fire_err  = 1'b0;
        fire_data = 32'h0;
        case (state)
            ARB_IDLE: begin
                if (arb_valid && !ram_addr_legal(sel_addr, RAM_BASE)) begin
                    fire     = 1'b1;
                    fire_id  = arb_id;
                    fire_err = 1'b1;
                end
            end
            ARB_ISSUE: begin
                if (ram_ready) begin
                    fire      = 1'b1;
                    fire_data = lat_we ? 32'h0 : ram_rdata;
                end else if (cnt == CNT_LAST) begin
                    fire     = 1'b1;
                    fire_err = 1'b1;
                end
            end
            default: begin
                fire = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            last_grant <= ID_VGA;
            grant_id   <= 1'b0;
            cur_id     <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            cnt        <= '0;
            cpu_ack    <= 1'b0;
            cpu_err    <= 1'b0;
            cpu_rdata  <= 32'h0;
            vga_ack    <= 1'b0;
            vga_err    <= 1'b0;
            vga_rdata  <= 32'h0;
        end else begin
            cpu_ack <= 1'b0;
            vga_ack <= 1'b0;

            case (state)
                ARB_IDLE: begin
                    if (arb_valid) begin
                        cur_id     <= arb_id;
                        last_grant <= arb_id;
                        grant_id   <= arb_id;
                        lat_we     <= sel_we;
                        lat_addr   <= sel_addr;
                        lat_wdata  <= sel_wdata;
                        cnt        <= '0;
                        state      <= fire ? ARB_RESP : ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (fire) begin
                        state <= ARB_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ARB_RESP: begin
                    cnt   <= '0;
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase

            if (fire) begin
                if (fire_id == ID_VGA) begin
                    vga_ack   <= 1'b1;
                    vga_err   <= fire_err;
                    vga_rdata <= fire_data;
                end else begin
                    cpu_ack   <= 1'b1;
                    cpu_err   <= fire_err;
                    cpu_rdata <= fire_data;
                end
            end
        end
    end

    assign ram_req   = (state == ARB_ISSUE);
    assign ram_we    = lat_we;
    assign ram_addr  = lat_addr;
    assign ram_wdata = lat_wdata;
    assign busy      = (state != ARB_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a latency-programmable RAM model, an ack scoreboard fed from
// exp_q, and directed checks of latency, arbitration order, rejection, timeout and reset abort.
module tb_ram_arbiter;
    import bridge_pkg::*;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_ack, cpu_err;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        vga_req, vga_we, vga_ack, vga_err;
    logic [31:0] vga_addr, vga_wdata, vga_rdata;
    logic        ram_req, ram_we, ram_ready;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        busy, grant_id;
    arb_state_e  dbg_state;

    ram_arbiter #(.RAM_BASE(32'h0020_0000), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .cpu_err   (cpu_err),
        .vga_req   (vga_req),
        .vga_we    (vga_we),
        .vga_addr  (vga_addr),
        .vga_wdata (vga_wdata),
        .vga_rdata (vga_rdata),
        .vga_ack   (vga_ack),
        .vga_err   (vga_err),
        .ram_req   (ram_req),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ready (ram_ready),
        .busy      (busy),
        .grant_id  (grant_id),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          passes = 0;
    int          pushes = 0;
    int          acks_seen = 0;
    logic [33:0] exp_q[$];
    logic [33:0] mon_obs;
    logic [33:0] mon_exp;

    // RAM model: ram_ready on the ram_lat-th cycle of ram_req (0 = never).
    int          ram_lat = 0;
    int          issue_cnt = 0;
    int          ram_req_cycles = 0;
    logic [31:0] ram_ret = 32'h0;

    task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic id, input logic err, input logic [31:0] data);
        exp_q.push_back({id, err, data});
        pushes++;
    endtask

    task automatic drive_cpu(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    task automatic drive_vga(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        vga_req   = 1'b1;
        vga_we    = we;
        vga_addr  = addr;
        vga_wdata = wdata;
    endtask

    task automatic wait_ack(input int budget, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!(cpu_ack || vga_ack) && lat < budget);
        check("ack_within_budget", 34'(cpu_ack || vga_ack), 34'd1);
    endtask

    always @(negedge clk) begin
        if (ram_req) begin
            issue_cnt++;
            ram_req_cycles++;
            ram_ready = (ram_lat != 0) && (issue_cnt == ram_lat);
        end else begin
            issue_cnt = 0;
            ram_ready = 1'b0;
        end
        ram_rdata = ram_ret;
    end

    always @(negedge clk) begin
        if (!rst && (cpu_ack || vga_ack)) begin
            acks_seen++;
            check("ack_overlap", 34'(cpu_ack && vga_ack), 34'd0);
            check("grant_id_at_ack", 34'(grant_id), 34'(vga_ack));
            mon_obs = {vga_ack, vga_ack ? vga_err : cpu_err, vga_ack ? vga_rdata : cpu_rdata};
            check("sb_has_entry", 34'(exp_q.size() != 0), 34'd1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check("sb_id_err_rdata", mon_obs, mon_exp);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int lat;

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        vga_req = 1'b0; vga_we = 1'b0; vga_addr = 32'h0; vga_wdata = 32'h0;
        ram_ready = 1'b0; ram_rdata = 32'h0;

        // Reset state
        tick();
        tick();
        check("rst_busy", 34'(busy), 34'd0);
        check("rst_ram_req", 34'(ram_req), 34'd0);
        check("rst_acks", 34'({cpu_ack, vga_ack}), 34'd0);
        check("rst_grant_id", 34'(grant_id), 34'd0);
        check("rst_rdata", 34'(cpu_rdata | vga_rdata), 34'd0);
        check("rst_state", 34'(dbg_state), 34'(ARB_IDLE));
        rst = 1'b0;
        tick();

        // CPU read with ram_ready in the first ISSUE cycle
        ram_lat = 1;
        ram_ret = 32'hDEAD_BEEF;
        push_exp(ID_CPU, 1'b0, 32'hDEAD_BEEF);
        drive_cpu(1'b0, 32'h0020_0010, 32'h0);
        tick();
        check("rd_ram_req", 34'(ram_req), 34'd1);
        check("rd_ram_addr", 34'(ram_addr), 34'h0020_0010);
        check("rd_ram_we", 34'(ram_we), 34'd0);
        check("rd_no_early_ack", 34'(cpu_ack), 34'd0);
        wait_ack(10, lat);
        check("rd_latency", 34'(lat + 1), 34'd2);
        check("rd_cpu_ack", 34'(cpu_ack), 34'd1);
        check("rd_cpu_rdata", 34'(cpu_rdata), 34'hDEAD_BEEF);
        check("rd_cpu_err", 34'(cpu_err), 34'd0);
        check("rd_vga_ack", 34'(vga_ack), 34'd0);
        cpu_req = 1'b0;
        tick();

        // Round robin from reset: both held high, order CPU, VGA, CPU, VGA
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ram_ret = 32'h0BAD_F00D;
        for (int k = 0; k < 4; k++) push_exp(logic'(k % 2), 1'b0, 32'h0BAD_F00D);
        drive_cpu(1'b0, 32'h0020_0100, 32'h0);
        drive_vga(1'b0, 32'h0020_0200, 32'h0);
        for (int k = 0; k < 4; k++) begin
            wait_ack(10, lat);
            check("rr_winner", 34'(vga_ack), 34'(k % 2));
            check("rr_grant_id", 34'(grant_id), 34'(k % 2));
        end
        cpu_req = 1'b0;
        vga_req = 1'b0;
        tick();

        // Rejected addresses: below RAM_BASE and misaligned
        ram_req_cycles = 0;
        push_exp(ID_VGA, 1'b1, 32'h0);
        drive_vga(1'b1, 32'h0000_4000, 32'h1234_5678);
        wait_ack(10, lat);
        check("low_latency", 34'(lat), 34'd1);
        check("low_vga_err", 34'(vga_err), 34'd1);
        check("low_vga_rdata", 34'(vga_rdata), 34'd0);
        vga_req = 1'b0;
        tick();
        push_exp(ID_CPU, 1'b1, 32'h0);
        drive_cpu(1'b0, 32'h0020_0002, 32'h0);
        wait_ack(10, lat);
        check("mis_latency", 34'(lat), 34'd1);
        check("mis_cpu_err", 34'(cpu_err), 34'd1);
        cpu_req = 1'b0;
        tick();
        check("rej_no_ram_req", 34'(ram_req_cycles), 34'd0);

        // Timeout: ram_ready never comes
        ram_lat = 0;
        ram_req_cycles = 0;
        ram_ret = 32'h7777_7777;
        push_exp(ID_CPU, 1'b1, 32'h0);
        drive_cpu(1'b0, 32'h0020_0020, 32'h0);
        wait_ack(40, lat);
        check("to_latency", 34'(lat), 34'd17);
        check("to_ram_req_cycles", 34'(ram_req_cycles), 34'd16);
        check("to_cpu_err", 34'(cpu_err), 34'd1);
        check("to_cpu_rdata", 34'(cpu_rdata), 34'd0);
        cpu_req = 1'b0;
        tick();

        // ram_ready on the 16th ISSUE cycle wins over the timeout
        ram_lat = 16;
        ram_req_cycles = 0;
        ram_ret = 32'hCAFE_0001;
        push_exp(ID_CPU, 1'b0, 32'hCAFE_0001);
        drive_cpu(1'b0, 32'h0020_0024, 32'h0);
        wait_ack(40, lat);
        check("edge_latency", 34'(lat), 34'd17);
        check("edge_ram_req_cycles", 34'(ram_req_cycles), 34'd16);
        check("edge_cpu_err", 34'(cpu_err), 34'd0);
        cpu_req = 1'b0;
        tick();

        // Write: RAM read data ignored, rdata returns 0
        ram_lat = 2;
        ram_ret = 32'hFFFF_FFFF;
        push_exp(ID_CPU, 1'b0, 32'h0);
        drive_cpu(1'b1, 32'h0020_0040, 32'h55AA_33CC);
        tick();
        check("wr_ram_we", 34'(ram_we), 34'd1);
        check("wr_ram_addr", 34'(ram_addr), 34'h0020_0040);
        check("wr_ram_wdata", 34'(ram_wdata), 34'h55AA_33CC);
        wait_ack(10, lat);
        check("wr_latency", 34'(lat + 1), 34'd3);
        check("wr_cpu_rdata", 34'(cpu_rdata), 34'd0);
        cpu_req = 1'b0;
        tick();

        // Reset during ISSUE, then pending CPU and VGA resolve CPU first
        ram_lat = 0;
        drive_cpu(1'b0, 32'h0020_0050, 32'h0);
        tick();
        tick();
        check("mr_in_issue", 34'(ram_req), 34'd1);
        drive_vga(1'b0, 32'h0020_0060, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("mr_ram_req", 34'(ram_req), 34'd0);
        check("mr_busy", 34'(busy), 34'd0);
        check("mr_acks", 34'({cpu_ack, vga_ack}), 34'd0);
        ram_lat = 1;
        ram_ret = 32'h1357_9BDF;
        tick();
        rst = 1'b0;
        push_exp(ID_CPU, 1'b0, 32'h1357_9BDF);
        push_exp(ID_VGA, 1'b0, 32'h1357_9BDF);
        wait_ack(10, lat);
        check("mr_first_cpu", 34'(cpu_ack), 34'd1);
        cpu_req = 1'b0;
        wait_ack(10, lat);
        check("mr_then_vga", 34'(vga_ack), 34'd1);
        vga_req = 1'b0;
        tick();

        // CPU drops req while in ISSUE: transaction still completes once
        ram_lat = 3;
        ram_ret = 32'h2468_ACE0;
        push_exp(ID_CPU, 1'b0, 32'h2468_ACE0);
        drive_cpu(1'b0, 32'h0020_0080, 32'h0);
        tick();
        cpu_req = 1'b0;
        wait_ack(10, lat);
        check("drop_latency", 34'(lat), 34'd3);
        check("drop_cpu_ack", 34'(cpu_ack), 34'd1);
        tick();
        check("drop_busy", 34'(busy), 34'd0);
        check("drop_state", 34'(dbg_state), 34'(ARB_IDLE));
        check("drop_single_ack", 34'(cpu_ack), 34'd0);
        tick();
        tick();

        check("sb_drained", 34'(exp_q.size()), 34'd0);
        check("ack_count", 34'(acks_seen), 34'(pushes));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
